// File: rtl/div_seq.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per clock.
// Defining DIV_REMAINDER_EN adds the data_remainder port and its sign-fix logic.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic             r_sign_q;
  logic             r_exc;
`ifdef DIV_REMAINDER_EN
  logic             r_sign_r;
`endif

  // Magnitudes are formed one bit wider so |MIN_NEG| is representable.
  logic [WIDTH:0]   w_a_ext, w_b_ext, w_abs_a, w_abs_b;
  logic             w_div_zero, w_ovf, w_exc_start;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge, w_last;
  logic [WIDTH-1:0] w_quot;
  logic             w_unused;

  assign w_a_ext     = {data_operandA[WIDTH-1], data_operandA};
  assign w_b_ext     = {data_operandB[WIDTH-1], data_operandB};
  assign w_abs_a     = data_operandA[WIDTH-1] ? -w_a_ext : w_a_ext;
  assign w_abs_b     = data_operandB[WIDTH-1] ? -w_b_ext : w_b_ext;
  assign w_div_zero  = (data_operandB == '0);
  assign w_ovf       = (data_operandA == MIN_NEG) && (data_operandB == '1);
  assign w_exc_start = w_div_zero | w_ovf;

  // Partial remainder stays below |B| <= 2^(WIDTH-1), so WIDTH bits hold it between steps.
  assign w_shift  = {r_r, r_q[WIDTH-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_b};
  assign w_ge     = ~w_diff[WIDTH+1];
  assign w_last   = (r_count == CW'(WIDTH - 1));
  assign w_quot   = r_sign_q ? -r_q : r_q;
  assign w_unused = ^{w_abs_a[WIDTH], w_abs_b[WIDTH], w_diff[WIDTH]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // A start pulse wins in every state, which is how an in-flight divide is aborted.
  always_comb begin
    w_state_next = r_state;
    if (ctrl_DIV) begin
      w_state_next = w_exc_start ? S_FIX : S_CALC;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_CALC:  if (w_last) w_state_next = S_FIX;
        S_FIX:   w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count        <= '0;
      r_q            <= '0;
      r_r            <= '0;
      r_b            <= '0;
      r_sign_q       <= 1'b0;
      r_exc          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_sign_r       <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        r_count <= '0;
        r_b     <= w_abs_b[WIDTH-1:0];
        // Exceptions preload final magnitudes with signs cleared so FIX passes them through.
        if (w_div_zero) begin
          r_q      <= '0;
          r_r      <= data_operandA;
          r_sign_q <= 1'b0;
          r_exc    <= 1'b1;
`ifdef DIV_REMAINDER_EN
          r_sign_r <= 1'b0;
`endif
        end else if (w_ovf) begin
          r_q      <= MIN_NEG;
          r_r      <= '0;
          r_sign_q <= 1'b0;
          r_exc    <= 1'b1;
`ifdef DIV_REMAINDER_EN
          r_sign_r <= 1'b0;
`endif
        end else begin
          r_q      <= w_abs_a[WIDTH-1:0];
          r_r      <= '0;
          r_sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          r_exc    <= 1'b0;
`ifdef DIV_REMAINDER_EN
          r_sign_r <= data_operandA[WIDTH-1];
`endif
        end
      end else begin
        case (r_state)
          S_CALC: begin
            r_r     <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_q     <= {r_q[WIDTH-2:0], w_ge};
            r_count <= r_count + 1'b1;
          end
          S_FIX: begin
            data_result    <= w_quot;
            data_exception <= r_exc;
            data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
            data_remainder <= r_sign_r ? -r_r : r_r;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
